// File: rtl/thread_pc_unit_pkg.sv
// Shared types and defaults for the per-thread PC store.
// Pure declarations: no logic, no latency, no flow control.
// Optional THREAD_PC_ALIGN_CHECK_EN uses align_word below.
package thread_pc_unit_pkg;

    localparam int n_threads  = 4;
    localparam int threadid_w = $clog2(n_threads);

    typedef logic [31:0]           vptr_t;
    typedef logic [threadid_w-1:0] threadid_t;

    localparam vptr_t RESET_PC_DEF   = 32'h0000_1000;
    localparam vptr_t EXC_VECTOR_DEF = 32'h0000_2000;

    function automatic vptr_t align_word(input vptr_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/thread_pc_unit_if.sv
// Scheduler/redirect/fetch bundle around the PC store; master = pipeline side.
// Combinational wires only; no handshake, every event is a one-cycle enable.
// THREAD_PC_ALIGN_CHECK_EN adds the pc_misaligned return signal.
interface thread_pc_unit_if;
    import thread_pc_unit_pkg::*;

    threadid_t              sched_thread;
    logic [n_threads-1:0]   stalled;
    vptr_t                  pc;
    logic                   miss_en;
    threadid_t              miss_thread;
    vptr_t                  miss_pc;
    logic                   br_en;
    threadid_t              br_thread;
    vptr_t                  br_target;
    logic                   exc_en;
    threadid_t              exc_thread;
    vptr_t                  exc_pc;
    logic                   eret_en;
    threadid_t              eret_thread;
    threadid_t              epc_thread;
    vptr_t                  epc;
`ifdef THREAD_PC_ALIGN_CHECK_EN
    logic                   pc_misaligned;

    modport master (
        output sched_thread, stalled, miss_en, miss_thread, miss_pc,
               br_en, br_thread, br_target, exc_en, exc_thread, exc_pc,
               eret_en, eret_thread, epc_thread,
        input  pc, epc, pc_misaligned
    );
    modport slave (
        input  sched_thread, stalled, miss_en, miss_thread, miss_pc,
               br_en, br_thread, br_target, exc_en, exc_thread, exc_pc,
               eret_en, eret_thread, epc_thread,
        output pc, epc, pc_misaligned
    );
`else
    modport master (
        output sched_thread, stalled, miss_en, miss_thread, miss_pc,
               br_en, br_thread, br_target, exc_en, exc_thread, exc_pc,
               eret_en, eret_thread, epc_thread,
        input  pc, epc
    );
    modport slave (
        input  sched_thread, stalled, miss_en, miss_thread, miss_pc,
               br_en, br_thread, br_target, exc_en, exc_thread, exc_pc,
               eret_en, eret_thread, epc_thread,
        output pc, epc
    );
`endif

endinterface

// File: rtl/thread_pc_slot.sv
// One thread's pc/epc register pair with redirect priority exc > eret > br > miss > step.
// Registered state, outputs are the raw flops; no backpressure (stall only gates the step).
// THREAD_PC_ALIGN_CHECK_EN: force br/eret targets word aligned and flag it.
module thread_pc_slot
    import thread_pc_unit_pkg::*;
#(
    parameter vptr_t RESET_PC   = RESET_PC_DEF,
    parameter vptr_t EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int    PC_STEP    = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  exc_hit,
    input  vptr_t exc_pc,
    input  logic  eret_hit,
    input  logic  br_hit,
    input  vptr_t br_target,
    input  logic  miss_hit,
    input  vptr_t miss_pc,
    input  logic  inc_en,
`ifdef THREAD_PC_ALIGN_CHECK_EN
    output logic  misaligned,
`endif
    output vptr_t pc_q,
    output vptr_t epc_q
);

    vptr_t pc_d;
    vptr_t epc_d;
`ifdef THREAD_PC_ALIGN_CHECK_EN
    logic  mis_d;
    logic  mis_q;
    assign misaligned = mis_q;
`endif

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
`ifdef THREAD_PC_ALIGN_CHECK_EN
        mis_d = 1'b0;
`endif
        if (exc_hit) begin
            pc_d  = EXC_VECTOR;
            epc_d = exc_pc;
        end else if (eret_hit) begin
`ifdef THREAD_PC_ALIGN_CHECK_EN
            pc_d  = align_word(epc_q);
            mis_d = |epc_q[1:0];
`else
            pc_d  = epc_q;
`endif
        end else if (br_hit) begin
`ifdef THREAD_PC_ALIGN_CHECK_EN
            pc_d  = align_word(br_target);
            mis_d = |br_target[1:0];
`else
            pc_d  = br_target;
`endif
        end else if (miss_hit) begin
            // Rewinds the speculative step taken when the missing fetch issued.
            pc_d = miss_pc;
        end else if (inc_en) begin
            pc_d = pc_q + vptr_t'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            epc_q <= '0;
`ifdef THREAD_PC_ALIGN_CHECK_EN
            mis_q <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
`ifdef THREAD_PC_ALIGN_CHECK_EN
            mis_q <= mis_d;
`endif
        end
    end

endmodule

// File: rtl/thread_pc_unit.sv
// Per-thread PC store feeding fetch: decodes events per thread, muxes pc/epc reads.
// pc and epc are zero-latency reads of state; updates land on the next edge; no backpressure.
// THREAD_PC_ALIGN_CHECK_EN adds pc_misaligned on the interface.
module thread_pc_unit
    import thread_pc_unit_pkg::*;
#(
    parameter int    N_THREADS  = n_threads,
    parameter vptr_t RESET_PC   = RESET_PC_DEF,
    parameter vptr_t EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int    PC_STEP    = 4
) (
    input logic              clk,
    input logic              rst,
    thread_pc_unit_if.slave  bus
);

    vptr_t pc_arr  [N_THREADS];
    vptr_t epc_arr [N_THREADS];
`ifdef THREAD_PC_ALIGN_CHECK_EN
    logic [N_THREADS-1:0] mis_vec;
    assign bus.pc_misaligned = |mis_vec;
`endif

    for (genvar t = 0; t < N_THREADS; t++) begin : g_slot
        thread_pc_slot #(
            .RESET_PC   (RESET_PC),
            .EXC_VECTOR (EXC_VECTOR),
            .PC_STEP    (PC_STEP)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .exc_hit    (bus.exc_en  && (bus.exc_thread  == threadid_t'(t))),
            .exc_pc     (bus.exc_pc),
            .eret_hit   (bus.eret_en && (bus.eret_thread == threadid_t'(t))),
            .br_hit     (bus.br_en   && (bus.br_thread   == threadid_t'(t))),
            .br_target  (bus.br_target),
            .miss_hit   (bus.miss_en && (bus.miss_thread == threadid_t'(t))),
            .miss_pc    (bus.miss_pc),
            .inc_en     ((bus.sched_thread == threadid_t'(t)) && !bus.stalled[t]),
`ifdef THREAD_PC_ALIGN_CHECK_EN
            .misaligned (mis_vec[t]),
`endif
            .pc_q       (pc_arr[t]),
            .epc_q      (epc_arr[t])
        );
    end

    assign bus.pc  = pc_arr[bus.sched_thread];
    assign bus.epc = epc_arr[bus.epc_thread];

endmodule

// File: doc/thread_pc_unit.md
Name: thread_pc_unit

Overview:
Per-thread program-counter store directly upstream of the fetch stage. Drives the fetch PC for the thread the scheduler selects each cycle. After each issued fetch it speculatively advances that thread's PC by one word. Applies redirects from later pipeline events: fetch-miss replay, taken branch, exception entry and exception return. Keeps a per-thread saved-exception PC (EPC).

Parameters:
N_THREADS, 4, number of hardware threads; equals common n_threads.
RESET_PC, 32'h0000_1000, PC loaded into every thread on reset.
EXC_VECTOR, 32'h0000_2000, exception handler entry PC.
PC_STEP, 4, speculative increment in bytes.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-low reset.
sched_thread  input  threadid_t  thread fetched this cycle; scheduler output, already registered.
stalled  input  N_THREADS  per-thread stall mask from the I-cache/scheduler.
pc  output  vptr_t  fetch PC for sched_thread, to fetch stage.
miss_en  input  1  fetch of miss_thread missed in I-TLB or I-cache; replay.
miss_thread  input  threadid_t  thread to replay.
miss_pc  input  vptr_t  PC that missed.
br_en  input  1  taken branch/jump resolved.
br_thread  input  threadid_t  thread of the branch.
br_target  input  vptr_t  branch target.
exc_en  input  1  exception taken.
exc_thread  input  threadid_t  excepting thread.
exc_pc  input  vptr_t  faulting instruction PC.
eret_en  input  1  return from exception.
eret_thread  input  threadid_t  returning thread.
epc_thread  input  threadid_t  EPC read select.
epc  output  vptr_t  EPC of epc_thread, combinational read.

Behaviour:
- State: pc_q[N_THREADS], epc_q[N_THREADS], all vptr_t.
- Reset (rst==0 at posedge): every pc_q = RESET_PC; every epc_q = 0. Out of reset, pc = RESET_PC and epc = 0 on the next cycle.
- pc = pc_q[sched_thread], combinational, zero latency. This lets fetch translate in the same cycle.
- Per thread t, next-state priority, evaluated independently for each thread each cycle:
  - exc_en && exc_thread==t: pc_q[t] <= EXC_VECTOR; epc_q[t] <= exc_pc.
  - else eret_en && eret_thread==t: pc_q[t] <= epc_q[t].
  - else br_en && br_thread==t: pc_q[t] <= br_target. Branch is older than the fetch miss, so it wins.
  - else miss_en && miss_thread==t: pc_q[t] <= miss_pc. This rewinds the speculative increment.
  - else t==sched_thread && !stalled[t]: pc_q[t] <= pc_q[t] + PC_STEP.
  - else hold.
- Events that name different threads in the same cycle all take effect.
- The sequential increment applies only to sched_thread.
- Arithmetic: 32-bit unsigned add; wrap 32'hFFFF_FFFC+4 -> 0. No overflow flag.
- Stalled thread: PC held; redirects still apply.
- Both exc_en and eret_en on the same thread: exception wins. EPC is overwritten with exc_pc and pc_q goes to EXC_VECTOR.
- EPC read-during-write: epc returns the old value; the new value is visible next cycle.
- Reset mid-operation overrides all events in that cycle.

Optional Feature:
THREAD_PC_ALIGN_CHECK_EN
- Enabled: extra output pc_misaligned (1 bit, registered, reset 0). It pulses for one cycle the cycle after a br_target or eret-restored PC with bits[1:0]!=0 is written. The PC is still written, with bits[1:0] forced to 0.
- Disabled: the port is absent; targets are written unmodified.

Decomposition:
- Shared package (common): vptr_t, threadid_t, n_threads, and the RESET_PC/EXC_VECTOR defaults as localparams.
- One natural sub-module, thread_pc_slot: the single-thread pc/epc register pair with the priority mux above, instantiated N_THREADS times by a generate loop. The top level does the event decode and the sched_thread read mux.

Test Plan:
1. Reset, then sched_thread cycling 0,1,2,3 with no stalls: pc sequence 0x1000,0x1000,0x1000,0x1000, then 0x1004 for each thread on the second pass.
2. stalled[2]=1 while sched_thread=2 for 3 cycles: pc stays 0x1000; after release it increments to 0x1004.
3. Thread 1 fetches 0x1004, then next cycle miss_en with miss_pc=0x1004: thread 1's pc reads 0x1004 again, not 0x1008.
4. Same cycle br_en thread0 target 0x3000 and miss_en thread0 pc 0x1008: pc_q[0]=0x3000. Same cycle miss on thread3 also applies.
5. exc_en thread2 exc_pc 0x1010 -> pc_q[2]=0x2000, epc(2)=0x1010 next cycle. eret_en thread2 -> pc_q[2]=0x1010.
6. Reset asserted mid-run with exc_en active: all pc_q=0x1000, all epc=0. With THREAD_PC_ALIGN_CHECK_EN, br_target 0x3002 -> pc_q=0x3000 and pc_misaligned pulses for one cycle.
